// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two write ports and a busy scoreboard.
// Optional same-cycle write-to-read forwarding via `define REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 1 << ADDR_WIDTH,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we0,
    input  logic [ADDR_WIDTH-1:0]        waddr0,
    input  logic [DATA_WIDTH-1:0]        wdata0,
    input  logic                         we1,
    input  logic [ADDR_WIDTH-1:0]        waddr1,
    input  logic [DATA_WIDTH-1:0]        wdata1,
    input  logic [NUM_RD-1:0]            re,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    output logic [NUM_RD-1:0]            rbusy,
    input  logic                         alloc_en,
    input  logic [ADDR_WIDTH-1:0]        alloc_addr,
    output logic                         alloc_ok,
    output logic [NUM_REGS-1:0]          busy_vec
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;
    logic                  w0_ok;
    logic                  w1_ok;
    logic                  alloc_acc;

    // An address is "live" if it names real, writable storage.
    function automatic logic live(input logic [ADDR_WIDTH-1:0] a);
        return (32'(a) < NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign w0_ok     = we0 && live(waddr0);
    assign w1_ok     = we1 && live(waddr1);
    assign alloc_acc = alloc_en && live(alloc_addr) && !busy_q[alloc_addr];
    assign alloc_ok  = !rst && (!live(alloc_addr) || !busy_q[alloc_addr]);
    assign busy_vec  = rst ? '0 : busy_q[NUM_REGS-1:0];

    // Write clears come first so a same-cycle allocation leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (w0_ok) busy_d[waddr0] = 1'b0;
        if (w1_ok) busy_d[waddr1] = 1'b0;
        if (alloc_acc) busy_d[alloc_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) regs_q[r] <= '0;
            busy_q <= '0;
        end else begin
            if (w0_ok) regs_q[waddr0] <= wdata0;
            if (w1_ok) regs_q[waddr1] <= wdata1;
            busy_q <= busy_d;
        end
    end

    logic [ADDR_WIDTH-1:0] ra;
`ifdef REGFILE_BYPASS_EN
    logic hit0;
    logic hit1;
`endif

    always_comb begin
        rdata = '0;
        rbusy = '0;
        ra    = '0;
`ifdef REGFILE_BYPASS_EN
        hit0  = 1'b0;
        hit1  = 1'b0;
`endif
        for (int i = 0; i < NUM_RD; i++) begin
            ra = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            if (!rst && re[i] && live(ra)) begin
                rdata[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[ra];
                rbusy[i] = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
                hit0 = w0_ok && (waddr0 == ra);
                hit1 = w1_ok && (waddr1 == ra);
                if (hit1)
                    rdata[i*DATA_WIDTH +: DATA_WIDTH] = wdata1;
                else if (hit0)
                    rdata[i*DATA_WIDTH +: DATA_WIDTH] = wdata0;
                if (hit0 || hit1) rbusy[i] = 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of regfile_mp, default and 4-read/no-r0 variants.
// Expected bypass behaviour follows REGFILE_BYPASS_EN as defined for the build.
module tb_regfile_mp;

  int checks = 0;
  int errors = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [4:0]  waddr0 = '0, waddr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic [1:0]  re = '0;
  logic [9:0]  raddr = '0;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        alloc_en = 1'b0;
  logic [4:0]  alloc_addr = '0;
  logic        alloc_ok;
  logic [31:0] busy_vec;

  logic         b_we0 = 1'b0, b_we1 = 1'b0;
  logic [3:0]   b_waddr0 = '0, b_waddr1 = '0;
  logic [31:0]  b_wdata0 = '0, b_wdata1 = '0;
  logic [3:0]   b_re = '0;
  logic [15:0]  b_raddr = '0;
  logic [127:0] b_rdata;
  logic [3:0]   b_rbusy;
  logic         b_alloc_en = 1'b0;
  logic [3:0]   b_alloc_addr = '0;
  logic         b_alloc_ok;
  logic [15:0]  b_busy_vec;

  always #5 clk = ~clk;

  regfile_mp u_dut (
    .clk(clk), .rst(rst),
    .we0(we0), .waddr0(waddr0),
    .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1),
    .wdata1(wdata1),
    .re(re), .raddr(raddr),
    .rdata(rdata), .rbusy(rbusy),
    .alloc_en(alloc_en),
    .alloc_addr(alloc_addr),
    .alloc_ok(alloc_ok),
    .busy_vec(busy_vec)
  );

  regfile_mp #(
    .ADDR_WIDTH(4), .NUM_RD(4),
    .ZERO_REG(0)
  ) u_dut4 (
    .clk(clk), .rst(rst),
    .we0(b_we0), .waddr0(b_waddr0),
    .wdata0(b_wdata0),
    .we1(b_we1), .waddr1(b_waddr1),
    .wdata1(b_wdata1),
    .re(b_re), .raddr(b_raddr),
    .rdata(b_rdata), .rbusy(b_rbusy),
    .alloc_en(b_alloc_en),
    .alloc_addr(b_alloc_addr),
    .alloc_ok(b_alloc_ok),
    .busy_vec(b_busy_vec)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    re = 2'b11;
    raddr = {5'd1, 5'd5};
    alloc_addr = 5'd6;
    tick();
    tick();
    checks++;
    if (rdata !== 64'h0) begin
      errors++;
      $error("FAIL rst_rdata: %0h", rdata);
    end
    checks++;
    if (busy_vec !== 32'h0) begin
      errors++;
      $error("FAIL rst_busy: %0h", busy_vec);
    end
    checks++;
    if (alloc_ok !== 1'b0) begin
      errors++;
      $error("FAIL rst_alloc_ok: %0h", alloc_ok);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (alloc_ok !== 1'b1) begin
      errors++;
      $error("FAIL post_rst_alloc_ok: %0h", alloc_ok);
    end

    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h1234;
    alloc_en = 1'b1;
    tick();
    we0 = 1'b0; alloc_en = 1'b0;
    #1;
    checks++;
    if (rdata[31:0] !== 32'h1234) begin
      errors++;
      $error("FAIL r5_written: %0h", rdata[31:0]);
    end
    checks++;
    if (busy_vec !== 32'h40) begin
      errors++;
      $error("FAIL r6_busy: %0h", busy_vec);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rdata !== 64'h0) begin
      errors++;
      $error("FAIL mid_rst_rdata: %0h", rdata);
    end
    checks++;
    if (busy_vec !== 32'h0) begin
      errors++;
      $error("FAIL mid_rst_busy: %0h", busy_vec);
    end
    checks++;
    if (alloc_ok !== 1'b0) begin
      errors++;
      $error("FAIL mid_rst_alloc_ok: %0h", alloc_ok);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (rdata[31:0] !== 32'h0) begin
      errors++;
      $error("FAIL r5_after_rst: %0h", rdata[31:0]);
    end

    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'hAAAA;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h5555;
    tick();
    we0 = 1'b0; we1 = 1'b0;
    raddr = {5'd0, 5'd7};
    #1;
    checks++;
    if (rdata[31:0] !== 32'h5555) begin
      errors++;
      $error("FAIL dual_write_r7: %0h", rdata[31:0]);
    end

    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFF;
    alloc_addr = 5'd0; alloc_en = 1'b1;
    #1;
    checks++;
    if (alloc_ok !== 1'b1) begin
      errors++;
      $error("FAIL r0_alloc_ok: %0h", alloc_ok);
    end
    tick();
    we0 = 1'b0; alloc_en = 1'b0;
    raddr = {5'd0, 5'd0};
    #1;
    checks++;
    if (rdata !== 64'h0) begin
      errors++;
      $error("FAIL r0_reads_zero: %0h", rdata);
    end
    checks++;
    if (busy_vec !== 32'h0) begin
      errors++;
      $error("FAIL r0_not_busy: %0h", busy_vec);
    end

    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h11;
    we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h22;
    tick();
    we0 = 1'b0; we1 = 1'b0;
    raddr = {5'd4, 5'd3}; re = 2'b11;
    #1;
    checks++;
    if (rdata !== {32'h22, 32'h11}) begin
      errors++;
      $error("FAIL two_ports: %0h", rdata);
    end
    re = 2'b01;
    #1;
    checks++;
    if (rdata !== {32'h0, 32'h11}) begin
      errors++;
      $error("FAIL port1_disabled: %0h", rdata);
    end

    alloc_addr = 5'd9; alloc_en = 1'b1;
    #1;
    checks++;
    if (alloc_ok !== 1'b1) begin
      errors++;
      $error("FAIL r9_alloc_ok_free: %0h", alloc_ok);
    end
    tick();
    raddr = {5'd0, 5'd9}; re = 2'b01;
    #1;
    checks++;
    if (busy_vec !== 32'h200) begin
      errors++;
      $error("FAIL r9_busy_vec: %0h", busy_vec);
    end
    checks++;
    if (rbusy !== 2'b01) begin
      errors++;
      $error("FAIL r9_rbusy: %0h", rbusy);
    end
    checks++;
    if (alloc_ok !== 1'b0) begin
      errors++;
      $error("FAIL r9_alloc_ok_busy: %0h", alloc_ok);
    end
    tick();
    alloc_en = 1'b0;
    checks++;
    if (busy_vec !== 32'h200) begin
      errors++;
      $error("FAIL r9_realloc_nochange: %0h", busy_vec);
    end
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h99;
    #1;
`ifdef REGFILE_BYPASS_EN
    checks++;
    if (rbusy !== 2'b00) begin
      errors++;
      $error("FAIL r9_wr_rbusy: %0h", rbusy);
    end
`else
    checks++;
    if (rbusy !== 2'b01) begin
      errors++;
      $error("FAIL r9_wr_rbusy: %0h", rbusy);
    end
`endif
    tick();
    we0 = 1'b0;
    #1;
    checks++;
    if (busy_vec !== 32'h0) begin
      errors++;
      $error("FAIL r9_cleared: %0h", busy_vec);
    end
    checks++;
    if (rdata[31:0] !== 32'h99) begin
      errors++;
      $error("FAIL r9_data: %0h", rdata[31:0]);
    end
    alloc_en = 1'b1;
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h77;
    tick();
    alloc_en = 1'b0; we1 = 1'b0;
    #1;
    checks++;
    if (busy_vec !== 32'h200) begin
      errors++;
      $error("FAIL alloc_wr_same: %0h", busy_vec);
    end
    checks++;
    if (rdata[31:0] !== 32'h77) begin
      errors++;
      $error("FAIL alloc_wr_data: %0h", rdata[31:0]);
    end

    we0 = 1'b1; waddr0 = 5'd2; wdata0 = 32'h10;
    tick();
    raddr = {5'd0, 5'd2};
    wdata0 = 32'h20;
    #1;
`ifdef REGFILE_BYPASS_EN
    checks++;
    if (rdata[31:0] !== 32'h20) begin
      errors++;
      $error("FAIL r2_same_cycle: %0h", rdata[31:0]);
    end
`else
    checks++;
    if (rdata[31:0] !== 32'h10) begin
      errors++;
      $error("FAIL r2_same_cycle: %0h", rdata[31:0]);
    end
`endif
    checks++;
    if (rbusy !== 2'b00) begin
      errors++;
      $error("FAIL r2_rbusy: %0h", rbusy);
    end
    tick();
    we0 = 1'b0;
    #1;
    checks++;
    if (rdata[31:0] !== 32'h20) begin
      errors++;
      $error("FAIL r2_next_cycle: %0h", rdata[31:0]);
    end
    we0 = 1'b1; wdata0 = 32'h30;
    we1 = 1'b1; waddr1 = 5'd2; wdata1 = 32'h40;
    #1;
`ifdef REGFILE_BYPASS_EN
    checks++;
    if (rdata[31:0] !== 32'h40) begin
      errors++;
      $error("FAIL r2_bypass_prec: %0h", rdata[31:0]);
    end
`else
    checks++;
    if (rdata[31:0] !== 32'h20) begin
      errors++;
      $error("FAIL r2_bypass_prec: %0h", rdata[31:0]);
    end
`endif
    tick();
    we0 = 1'b0; we1 = 1'b0;
    #1;
    checks++;
    if (rdata[31:0] !== 32'h40) begin
      errors++;
      $error("FAIL r2_dual_final: %0h", rdata[31:0]);
    end

    b_we0 = 1'b1; b_waddr0 = 4'd0; b_wdata0 = 32'h9;
    b_alloc_en = 1'b1; b_alloc_addr = 4'd0;
    tick();
    b_we0 = 1'b0; b_alloc_en = 1'b0;
    b_raddr = '0; b_re = 4'hF;
    #1;
    checks++;
    if (b_rdata !== {4{32'h9}}) begin
      errors++;
      $error("FAIL p4_r0_all: %0h", b_rdata);
    end
    checks++;
    if (b_busy_vec !== 16'h1) begin
      errors++;
      $error("FAIL p4_r0_busy: %0h", b_busy_vec);
    end
    checks++;
    if (b_rbusy !== 4'hF) begin
      errors++;
      $error("FAIL p4_rbusy: %0h", b_rbusy);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
